// File: rtl/conv_bf16tomxint_stream.sv
// Streaming BF16 -> MX-int block converter.
// Two block buffers alternate: one fills while the other drains through a
// single registered output stage. Each block carries its own max exponent,
// rounding mode and Inf/NaN flag, all captured while the block fills.
module conv_bf16tomxint_stream #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [16*lanes-1:0]        i_bf16_vec,
  input  logic                       i_rnd_mode,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [bit_width*lanes-1:0] o_mx_vec,
  output logic [7:0]                 o_mx_exp,
  output logic                       o_last,
  output logic                       o_special
);

  localparam int B  = k / lanes;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);
  localparam int QMAX = 2 ** (bit_width - 1) - 1;
  localparam int RSH  = 9 - bit_width;

  logic [16*lanes-1:0] buf_q [2][B];
  logic [7:0]          emax_q [2];
  logic                rnd_q  [2];
  logic                spc_q  [2];

  logic [CW-1:0] fcnt_q, dcnt_q;
  logic          fptr_q, dptr_q;
  logic [1:0]    occ_q, occ_d;

  logic [7:0]                 beat_emax;
  logic                       beat_spc;
  logic [bit_width*lanes-1:0] mx_d;
  logic [16*lanes-1:0]        rd_beat;
  logic fill_acc, fill_done, out_hs, drain_done, avail, load, last_pend;

  // Denormals and zeros share the minimum exponent of 1.
  function automatic logic [7:0] eff_exp(input logic [7:0] ex);
    return (ex == 8'd0) ? 8'd1 : ex;
  endfunction

  // Scale one element to the block exponent; rounding is done on the
  // magnitude (symmetric) and the sign is applied afterwards.
  function automatic logic [bit_width-1:0] conv_elem(input logic [15:0] x,
                                                      input logic [7:0] emax,
                                                      input logic rtz);
    logic [7:0]  ex, sft, mag;
    logic [4:0]  r;
    logic [27:0] w;
    logic        inc;
    logic [8:0]  qm, qn;
    ex  = x[14:7];
    mag = {ex != 8'd0, x[6:0]};
    sft = emax - eff_exp(ex);
    if (sft >= 8'd16) return '0;
    r   = {1'b0, sft[3:0]} + 5'(RSH);
    w   = {mag, 20'b0} >> r;
    inc = !rtz && w[19] && ((|w[18:0]) || w[20]);
    qm  = {1'b0, w[27:20]} + 9'(inc);
    if (qm > 9'(QMAX)) qm = 9'(QMAX);
    qn  = x[15] ? (9'd0 - qm) : qm;
    return qn[bit_width-1:0];
  endfunction

  assign o_ready    = (occ_q < 2'd2);
  assign fill_acc   = i_valid && o_ready;
  assign fill_done  = fill_acc && (fcnt_q == LAST_BEAT);
  assign out_hs     = o_valid && i_ready;
  assign drain_done = out_hs && o_last;
  // A block whose final beat already sits in the output register no longer
  // has beats to load, though it still holds its buffer until handshake.
  assign last_pend  = o_valid && o_last;
  assign avail      = (occ_q > {1'b0, last_pend});
  assign load       = avail && (!o_valid || i_ready);
  assign occ_d      = occ_q + 2'(fill_done) - 2'(drain_done);
  assign rd_beat    = buf_q[dptr_q][dcnt_q];

  // Per-beat exponent maximum and special detection on the input side.
  always_comb begin
    beat_emax = 8'd1;
    beat_spc  = 1'b0;
    for (int l = 0; l < lanes; l++) begin
      if (eff_exp(i_bf16_vec[l*16+7 +: 8]) > beat_emax)
        beat_emax = eff_exp(i_bf16_vec[l*16+7 +: 8]);
      beat_spc = beat_spc | (i_bf16_vec[l*16+7 +: 8] == 8'hFF);
    end
  end

  // Convert the beat currently addressed by the drain side.
  always_comb begin
    mx_d = '0;
    for (int l = 0; l < lanes; l++)
      mx_d[l*bit_width +: bit_width] =
        conv_elem(rd_beat[l*16 +: 16], emax_q[dptr_q], rnd_q[dptr_q]);
  end

  // Raw element storage; contents are only meaningful once a block is full.
  always_ff @(posedge i_clk) begin
    if (fill_acc) buf_q[fptr_q][fcnt_q] <= i_bf16_vec;
  end

  // Per-block metadata, restarted on the first beat of each block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      emax_q <= '{default: 8'd0};
      rnd_q  <= '{default: 1'b0};
      spc_q  <= '{default: 1'b0};
    end else if (fill_acc) begin
      if (fcnt_q == '0) begin
        emax_q[fptr_q] <= beat_emax;
        rnd_q[fptr_q]  <= i_rnd_mode;
        spc_q[fptr_q]  <= beat_spc;
      end else begin
        if (beat_emax > emax_q[fptr_q]) emax_q[fptr_q] <= beat_emax;
        spc_q[fptr_q] <= spc_q[fptr_q] | beat_spc;
      end
    end
  end

  // Fill/drain pointers, occupancy and the registered output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcnt_q    <= '0;
      dcnt_q    <= '0;
      fptr_q    <= 1'b0;
      dptr_q    <= 1'b0;
      occ_q     <= 2'd0;
      o_valid   <= 1'b0;
      o_mx_vec  <= '0;
      o_mx_exp  <= 8'd0;
      o_last    <= 1'b0;
      o_special <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (fill_acc) begin
        fcnt_q <= fill_done ? '0 : fcnt_q + 1'b1;
        if (fill_done) fptr_q <= ~fptr_q;
      end
      if (load) begin
        o_valid   <= 1'b1;
        o_mx_vec  <= spc_q[dptr_q] ? '0 : mx_d;
        o_mx_exp  <= spc_q[dptr_q] ? 8'hFF : emax_q[dptr_q];
        o_last    <= (dcnt_q == LAST_BEAT);
        o_special <= spc_q[dptr_q];
        dcnt_q    <= (dcnt_q == LAST_BEAT) ? '0 : dcnt_q + 1'b1;
        if (dcnt_q == LAST_BEAT) dptr_q <= ~dptr_q;
      end else if (out_hs) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_bf16tomxint_stream.sv
// Directed bench for conv_bf16tomxint_stream (bit_width=8, k=32, lanes=8).
module tb_conv_bf16tomxint_stream;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_bf16_vec;
  logic         i_rnd_mode;
  logic         o_valid;
  logic         i_ready;
  logic [63:0]  o_mx_vec;
  logic [7:0]   o_mx_exp;
  logic         o_last;
  logic         o_special;

  typedef struct {
    logic [63:0] vec;
    logic [7:0]  ex;
    logic        last;
    logic        spc;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] blk_in  [32];
  logic [7:0]  blk_out [32];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_beats  = 0;

  always #5 i_clk = ~i_clk;

  conv_bf16tomxint_stream #(.bit_width(8), .k(32), .lanes(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_bf16_vec (i_bf16_vec),
    .i_rnd_mode (i_rnd_mode),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_mx_vec   (o_mx_vec),
    .o_mx_exp   (o_mx_exp),
    .o_last     (o_last),
    .o_special  (o_special)
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errs++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic fill_blk(input logic [15:0] v_in, input logic [7:0] v_out);
    for (int i = 0; i < 32; i++) begin
      blk_in[i]  = v_in;
      blk_out[i] = v_out;
    end
  endtask

  task automatic expect_blk(input logic [7:0] ex, input logic spc);
    beat_t bt;
    for (int b = 0; b < 4; b++) begin
      for (int l = 0; l < 8; l++) bt.vec[l*8 +: 8] = blk_out[b*8+l];
      bt.ex   = ex;
      bt.last = (b == 3);
      bt.spc  = spc;
      exp_q.push_back(bt);
    end
  endtask

  // Rounding mode is inverted after the first beat: only beat 0 may count.
  task automatic send_blk(input int nb, input logic rnd);
    logic acc;
    int   guard;
    for (int b = 0; b < nb; b++) begin
      i_valid    = 1'b1;
      i_rnd_mode = (b == 0) ? rnd : ~rnd;
      for (int l = 0; l < 8; l++) i_bf16_vec[l*16 +: 16] = blk_in[b*8+l];
      guard = 0;
      do begin
        @(negedge i_clk);
        acc = o_ready;
        @(posedge i_clk);
        #1;
        guard++;
      end while (!acc && guard < 300);
      if (!acc) chk_val("accept_timeout", 64'(acc), 64'd1);
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(posedge i_clk);
      guard++;
    end
    #1;
    chk_val("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every output handshake is compared with the next expected beat.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk_val("unexpected_beat", 64'd1, 64'd0);
      end else begin
        beat_t bt;
        bt = exp_q.pop_front();
        chk_val($sformatf("vec[%0d]", n_beats), o_mx_vec, bt.vec);
        chk_val($sformatf("exp[%0d]", n_beats), 64'(o_mx_exp), 64'(bt.ex));
        chk_val($sformatf("last[%0d]", n_beats), 64'(o_last), 64'(bt.last));
        chk_val($sformatf("special[%0d]", n_beats), 64'(o_special), 64'(bt.spc));
      end
      n_beats++;
    end
  end

  initial begin
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_rnd_mode = 1'b0;
    i_bf16_vec = '0;
    #12;
    chk_val("rst_valid", 64'(o_valid), 64'd0);
    chk_val("rst_ready", 64'(o_ready), 64'd1);
    chk_val("rst_vec", o_mx_vec, 64'd0);
    chk_val("rst_exp", 64'(o_mx_exp), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // 1.0 everywhere; also first-beat latency.
    fill_blk(16'h3F80, 8'h40);
    expect_blk(8'd127, 1'b0);
    send_blk(4, 1'b0);
    chk_val("lat_pre", 64'(o_valid), 64'd0);
    @(posedge i_clk);
    #1;
    chk_val("lat_first", 64'(o_valid), 64'd1);
    wait_drain();

    // 2.0 sets e_max=128; -1.0 becomes -32.
    fill_blk(16'hBF80, 8'hE0);
    blk_in[0] = 16'h4000; blk_out[0] = 8'h40;
    expect_blk(8'd128, 1'b0);
    send_blk(4, 1'b0);
    wait_drain();

    // Ties at e_max=128: RNE then RTZ.
    fill_blk(16'h3F80, 8'h20);
    blk_in[0] = 16'h4000; blk_out[0] = 8'h40;
    blk_in[1] = 16'h3F82; blk_out[1] = 8'd32;
    blk_in[2] = 16'h3F86; blk_out[2] = 8'd34;
    expect_blk(8'd128, 1'b0);
    send_blk(4, 1'b0);
    blk_out[2] = 8'd33;
    expect_blk(8'd128, 1'b0);
    send_blk(4, 1'b1);
    wait_drain();

    // Saturation, signed zero, deep denormal, half-scale element.
    fill_blk(16'h3F80, 8'h40);
    blk_in[0] = 16'h3FFF; blk_out[0] = 8'h7F;
    blk_in[1] = 16'hBFFF; blk_out[1] = 8'h81;
    blk_in[2] = 16'h8000; blk_out[2] = 8'h00;
    blk_in[3] = 16'h0001; blk_out[3] = 8'h00;
    blk_in[4] = 16'h3F00; blk_out[4] = 8'h20;
    expect_blk(8'd127, 1'b0);
    send_blk(4, 1'b0);
    wait_drain();

    // NaN in beat 2 poisons the block; the following block is clean.
    fill_blk(16'h3F80, 8'h00);
    blk_in[19] = 16'h7FC0;
    expect_blk(8'hFF, 1'b1);
    send_blk(4, 1'b0);
    fill_blk(16'h3F80, 8'h40);
    expect_blk(8'd127, 1'b0);
    send_blk(4, 1'b0);
    wait_drain();

    // Backpressure: two blocks fill both buffers, third waits.
    i_ready = 1'b0;
    fill_blk(16'h3F80, 8'h40);
    expect_blk(8'd127, 1'b0);
    send_blk(4, 1'b0);
    fill_blk(16'hBF80, 8'hE0);
    blk_in[0] = 16'h4000; blk_out[0] = 8'h40;
    expect_blk(8'd128, 1'b0);
    send_blk(4, 1'b0);
    chk_val("bp_ready_low", 64'(o_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk);
      #1;
      chk_val("bp_hold_valid", 64'(o_valid), 64'd1);
      chk_val("bp_hold_vec", o_mx_vec, {8{8'h40}});
      chk_val("bp_hold_exp", 64'(o_mx_exp), 64'd127);
      chk_val("bp_hold_ready", 64'(o_ready), 64'd0);
    end
    fill_blk(16'h4080, 8'h40);
    expect_blk(8'd129, 1'b0);
    fork
      send_blk(4, 1'b0);
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a block discards it.
    fill_blk(16'h4100, 8'h00);
    send_blk(2, 1'b0);
    i_rst_n = 1'b0;
    #2;
    chk_val("mid_rst_valid", 64'(o_valid), 64'd0);
    chk_val("mid_rst_ready", 64'(o_ready), 64'd1);
    chk_val("mid_rst_vec", o_mx_vec, 64'd0);
    chk_val("mid_rst_exp", 64'(o_mx_exp), 64'd0);
    chk_val("mid_rst_last", 64'(o_last), 64'd0);
    chk_val("mid_rst_special", 64'(o_special), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    fill_blk(16'h3F80, 8'h40);
    expect_blk(8'd127, 1'b0);
    send_blk(4, 1'b0);
    wait_drain();

    repeat (3) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
